// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-line and received-word signals of the UART receiver.
//   baud_clk      oversample clock from the baud generator (sampled, not a clock)
//   rx            asynchronous serial line, idle high
//   data_out      last correctly framed received word
//   data_valid    one-CLK pulse when data_out is updated
//   framing_error one-CLK pulse when the stop bit samples low
//   busy          high whenever the receiver is not idle
// master: drives the line side and observes the results (bench / line driver).
// slave:  the receiver itself.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_clk;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_error;
    logic                 busy;

    modport master (
        output baud_clk,
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  baud_clk,
        input  rx,
        output data_out,
        output data_valid,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB-first, one start and one stop bit.
//   CLK  system clock, all state updates on its rising edge
//   RST  asynchronous active-high reset
//   bus  uart_rx_if.slave: baud_clk/rx in, data_out/data_valid/framing_error/busy out
// Start bit is confirmed at its midpoint; data and stop bits are then sampled
// every OVERSAMPLE ticks from that point, so only the tick count sets timing.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.slave  bus
);
    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);

    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q;
    logic [CntW-1:0]      tick_cnt_q;
    logic [BitW-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_valid_q;
    logic                 framing_error_q;
    logic                 baud_clk_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 tick;

    // One-CLK tick per rising edge of the sampled baud clock.
    assign tick = bus.baud_clk & ~baud_clk_q;

    // Edge detect and two-flop synchronizer; line idles high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            baud_clk_q <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
        end else begin
            baud_clk_q <= bus.baud_clk;
            rx_meta_q  <= bus.rx;
            rx_s_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= StIdle;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_s_q) begin
                            state_q    <= StStart;
                            tick_cnt_q <= '0;
                        end
                    end
                    StStart: begin
                        if (tick_cnt_q == CntHalf) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            // Line back high at mid-start: glitch, no frame.
                            state_q    <= rx_s_q ? StIdle : StData;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (tick_cnt_q == CntLast) begin
                            tick_cnt_q <= '0;
                            shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == BitLast) begin
                                bit_cnt_q <= '0;
                                state_q   <= StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (tick_cnt_q == CntLast) begin
                            tick_cnt_q <= '0;
                            state_q    <= StIdle;
                            if (rx_s_q) begin
                                data_out_q   <= shift_q;
                                data_valid_q <= 1'b1;
                            end else begin
                                framing_error_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.framing_error = framing_error_q;
    assign bus.busy          = (state_q != StIdle);
endmodule
